// File: rtl/output_register_sequencer.sv
// Output register sequencer for the Skein-1024 result bank: captures a finished
// hash state in one cycle, then unloads it as NUM_WORDS words over valid/ready.
module output_register_sequencer #(
   parameter int NUM_WORDS = 16,
   parameter int WORD_W    = 64,
   parameter int DROP_W    = 8,
   localparam int IDX_W    = $clog2(NUM_WORDS)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        done_i,
   output logic                        capture_ready_o,
   output logic [NUM_WORDS-1:0]        write_bits_o,
   input  logic [NUM_WORDS*WORD_W-1:0] state_i,
   input  logic                        abort_i,
   output logic [WORD_W-1:0]           word_o,
   output logic [IDX_W-1:0]            word_idx_o,
   output logic                        word_last_o,
   output logic                        word_valid_o,
   input  logic                        word_ready_i,
   output logic [DROP_W-1:0]           drop_cnt_o
);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } seq_state_t;

   seq_state_t          state_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DROP_W-1:0]   drop_q;
   logic [WORD_W-1:0]   words [NUM_WORDS];
   logic                is_last;
   logic                capture;
   logic                dropped;

   for (genvar g = 0; g < NUM_WORDS; g++) begin : g_split
      assign words[g] = state_i[g*WORD_W +: WORD_W];
   end

   // The bank only sees valid core data in the done_i cycle, so the write
   // enables must be combinational rather than registered.
   assign capture_ready_o = (state_q == IDLE) && !rst_i;
   assign capture         = done_i && capture_ready_o;
   assign dropped         = done_i && !rst_i && (state_q == DRAIN);
   assign write_bits_o    = {NUM_WORDS{capture}};

   assign is_last      = (idx_q == IDX_W'(NUM_WORDS - 1));
   assign word_valid_o = (state_q == DRAIN) && !rst_i;
   assign word_o       = words[idx_q];
   assign word_idx_o   = idx_q;
   assign word_last_o  = is_last;
   assign drop_cnt_o   = drop_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         drop_q  <= '0;
      end else begin
         if (dropped && (drop_q != {DROP_W{1'b1}})) begin
            drop_q <= drop_q + 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (capture) begin
                  state_q <= DRAIN;
                  idx_q   <= '0;
               end
            end
            DRAIN: begin
               // Abort wins over the handshake; a word accepted in the abort
               // cycle is still considered delivered.
               if (abort_i) begin
                  state_q <= IDLE;
                  idx_q   <= '0;
               end else if (word_ready_i) begin
                  if (is_last) begin
                     state_q <= IDLE;
                     idx_q   <= '0;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               idx_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_output_register_sequencer.sv
// Scoreboard bench for output_register_sequencer: a transaction-level model
// predicts stream words and per-cycle status; a monitor checks each transfer.
module tb_output_register_sequencer;

   localparam int NW = 16;
   localparam int WW = 64;

   typedef struct {
      logic [3:0]  idx;
      logic [63:0] data;
      logic        last;
   } word_t;

   logic           clk_i = 1'b0;
   logic           rst_i = 1'b1;
   logic           done_i = 1'b0;
   logic           abort_i = 1'b0;
   logic           word_ready_i = 1'b0;
   logic           capture_ready_o;
   logic [NW-1:0]  write_bits_o;
   logic [NW*WW-1:0] state_i;
   logic [WW-1:0]  word_o;
   logic [3:0]     word_idx_o;
   logic           word_last_o;
   logic           word_valid_o;
   logic [7:0]     drop_cnt_o;

   logic [63:0]    core_data [NW];
   logic [63:0]    bank [NW];

   word_t          exp_q [$];
   int             n_compared = 0;
   int             n_mismatched = 0;

   bit             m_drain = 1'b0;
   int             m_idx = 0;
   int             m_drop = 0;
   logic [63:0]    m_words [NW];
   bit             use_pattern = 1'b0;

   bit             e_cap;
   bit             e_valid;
   int             e_idx;
   int             e_drop;
   logic [NW-1:0]  e_wb;

   output_register_sequencer dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .done_i(done_i),
      .capture_ready_o(capture_ready_o),
      .write_bits_o(write_bits_o),
      .state_i(state_i),
      .abort_i(abort_i),
      .word_o(word_o),
      .word_idx_o(word_idx_o),
      .word_last_o(word_last_o),
      .word_valid_o(word_valid_o),
      .word_ready_i(word_ready_i),
      .drop_cnt_o(drop_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Behavioural stand-in for the register bank fed by the hash core.
   always @(posedge clk_i) begin
      for (int k = 0; k < NW; k++) begin
         if (write_bits_o[k]) bank[k] <= core_data[k];
      end
   end

   always_comb begin
      for (int k = 0; k < NW; k++) state_i[k*WW +: WW] = bank[k];
   end

   task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transfer monitor: every accepted word must be the next one predicted.
   always @(negedge clk_i) begin
      if (word_valid_o === 1'b1 && word_ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL unexpected_word: got idx %0d, expected no transfer (t=%0t)", word_idx_o, $time);
         end else begin
            word_t w;
            w = exp_q.pop_front();
            checkValue("xfer_idx", 64'(word_idx_o), 64'(w.idx));
            checkValue("xfer_data", word_o, w.data);
            checkValue("xfer_last", 64'(word_last_o), 64'(w.last));
         end
      end
   end

   task automatic checkOutput();
      checkValue("capture_ready", 64'(capture_ready_o), 64'(e_cap));
      checkValue("write_bits", 64'(write_bits_o), 64'(e_wb));
      checkValue("word_valid", 64'(word_valid_o), 64'(e_valid));
      checkValue("drop_cnt", 64'(drop_cnt_o), 64'(e_drop));
      if (e_valid) begin
         checkValue("hold_idx", 64'(word_idx_o), 64'(e_idx));
         checkValue("hold_data", word_o, m_words[e_idx]);
      end
   endtask

   // One clock cycle: drive inputs, predict this cycle, check, advance model.
   task automatic applyStimulus(input bit rst, input bit done, input bit abort, input bit ready);
      @(posedge clk_i);
      #1;
      rst_i        = rst;
      done_i       = done;
      abort_i      = abort;
      word_ready_i = ready;
      for (int k = 0; k < NW; k++) begin
         if (use_pattern) core_data[k] = 64'hA5A5_0000_0000_0000 + 64'(k);
         else             core_data[k] = {$urandom, $urandom};
      end
      e_cap   = !rst && !m_drain;
      e_valid = !rst && m_drain;
      e_wb    = (done && e_cap) ? {NW{1'b1}} : '0;
      e_idx   = m_idx;
      e_drop  = m_drop;
      if (e_valid && ready)
         exp_q.push_back('{idx: 4'(m_idx), data: m_words[m_idx], last: (m_idx == NW-1)});
      @(negedge clk_i);
      checkOutput();
      if (rst) begin
         m_drain = 1'b0;
         m_idx   = 0;
         m_drop  = 0;
      end else begin
         if (done && !e_cap && m_drop < 255) m_drop++;
         if (!m_drain) begin
            if (done) begin
               m_drain = 1'b1;
               m_idx   = 0;
               for (int k = 0; k < NW; k++) m_words[k] = core_data[k];
            end
         end else if (abort) begin
            m_drain = 1'b0;
            m_idx   = 0;
         end else if (ready) begin
            if (m_idx == NW-1) begin
               m_drain = 1'b0;
               m_idx   = 0;
            end else begin
               m_idx++;
            end
         end
      end
   endtask

   initial begin
      // Reset, including a done pulse that must be ignored and not counted.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 1);
      applyStimulus(0, 0, 0, 0);

      // Capture a known pattern and drain at full rate.
      use_pattern = 1'b1;
      applyStimulus(0, 1, 0, 1);
      use_pattern = 1'b0;
      for (int c = 0; c < 17; c++) applyStimulus(0, 0, 0, 1);

      // Backpressure with ready pattern 1,0,0,1.
      applyStimulus(0, 1, 0, 1);
      for (int c = 0; c < 40; c++) applyStimulus(0, 0, 0, (c % 4 == 0) || (c % 4 == 3));

      // Three overruns mid-drain, then saturation of the drop counter.
      applyStimulus(0, 1, 0, 1);
      for (int c = 0; c < 20; c++) applyStimulus(0, (c == 2 || c == 6 || c == 15), 0, 1);
      applyStimulus(0, 1, 0, 0);
      for (int c = 0; c < 300; c++) applyStimulus(0, 1, 0, 0);
      for (int c = 0; c < 17; c++) applyStimulus(0, 0, 0, 1);

      // Abort at idx 5 with a same-cycle handshake, then a fresh capture.
      applyStimulus(0, 1, 0, 1);
      for (int g = 0; g < 40 && m_idx != 5; g++) applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 1, 1);
      applyStimulus(0, 1, 0, 1);
      for (int c = 0; c < 17; c++) applyStimulus(0, 0, 0, 1);

      // Reset in the middle of a drain at idx 9.
      applyStimulus(0, 1, 0, 1);
      for (int g = 0; g < 40 && m_idx != 9; g++) applyStimulus(0, 0, 0, 1);
      applyStimulus(1, 1, 0, 1);
      applyStimulus(0, 0, 0, 1);

      // Randomized traffic.
      for (int c = 0; c < 600; c++)
         applyStimulus($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0);
      for (int c = 0; c < 20; c++) applyStimulus(0, 0, 0, 1);

      checkValue("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
